// File: rtl/mips_hazard_scoreboard.sv
// mips_hazard_scoreboard: RAW-hazard scoreboard for the MIPS-Lite pipeline.
// Tracks destination tags of instructions in the EX..WB stages and drives the
// decode-stage stall plus per-operand forwarding selects.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   id_valid             decode stage holds a real instruction
//   id_src1/_used        rs tag and read flag
//   id_src2/_used        rt tag and read flag
//   id_dest, id_writes   destination tag and write flag
//   id_is_load           decode instruction is LDW
//   flush                kill the decode instruction (priority over stall)
//   stall                hold IF/ID and insert a bubble into EX
//   fwd_sel1/2           0 = register file, k = result of stage k
//   inflight             valid-and-writes per stage, bit k-1 = stage k
// Optional feature macro HAZARD_STATS_EN adds saturating counters
//   stall_cycles and fwd_events.
module mips_hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int DEPTH    = 3,
  parameter int FORWARD  = 1,
  parameter int R0_ZERO  = 0,
  localparam int RW = $clog2(NUM_REGS),
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RW-1:0]    id_src1,
  input  logic             id_src1_used,
  input  logic [RW-1:0]    id_src2,
  input  logic             id_src2_used,
  input  logic [RW-1:0]    id_dest,
  input  logic             id_writes,
  input  logic             id_is_load,
  input  logic             flush,
  output logic             stall,
  output logic [SW-1:0]    fwd_sel1,
  output logic [SW-1:0]    fwd_sel2,
  output logic [DEPTH-1:0] inflight
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      fwd_events
`endif
);
  logic [DEPTH:1] r_vld, r_wr, r_ld;
  logic [RW-1:0]  r_dst [1:DEPTH];
  logic [DEPTH:1] w_m1, w_m2;
  logic [SW-1:0]  w_sel1, w_sel2;
  logic           w_hz, w_take;
  always_comb begin
    w_m1 = '0;
    w_m2 = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_m1[k] = id_src1_used & r_vld[k] & r_wr[k] & (r_dst[k] == id_src1) & !(R0_ZERO != 0 && id_src1 == '0);
      w_m2[k] = id_src2_used & r_vld[k] & r_wr[k] & (r_dst[k] == id_src2) & !(R0_ZERO != 0 && id_src2 == '0);
    end
  end
  // Scanning from the oldest stage down leaves the youngest producer selected.
  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_sel1 = w_m1[k] ? SW'(k) : w_sel1;
      w_sel2 = w_m2[k] ? SW'(k) : w_sel2;
    end
  end
  // With bypass only a load in EX can stall; without it every stage but WB
  // does, since WB writes the register file before decode reads it.
  always_comb begin
    w_hz = 1'b0;
    for (int k = 1; k <= DEPTH; k++)
      w_hz = w_hz | ((FORWARD != 0 ? (k == 1 && r_ld[1]) : (k < DEPTH)) & (w_m1[k] | w_m2[k]));
  end
  assign stall    = id_valid & !flush & w_hz;
  assign w_take   = id_valid & !flush & !w_hz;
  assign fwd_sel1 = FORWARD != 0 ? w_sel1 : '0;
  assign fwd_sel2 = FORWARD != 0 ? w_sel2 : '0;
  assign inflight = r_vld & r_wr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      r_wr  <= '0;
      r_ld  <= '0;
      for (int k = 1; k <= DEPTH; k++) r_dst[k] <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_wr[k]  <= r_wr[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_dst[k] <= r_dst[k-1];
      end
      r_vld[1] <= w_take;
      r_wr[1]  <= w_take & id_writes;
      r_ld[1]  <= w_take & id_is_load;
      r_dst[1] <= id_dest;
    end
  end
`ifdef HAZARD_STATS_EN
  logic [1:0]  w_nf;
  logic [32:0] w_fe;
  assign w_nf = {1'b0, fwd_sel1 != '0} + {1'b0, fwd_sel2 != '0};
  assign w_fe = {1'b0, fwd_events} + ((!stall && id_valid) ? 33'(w_nf) : 33'd0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      stall_cycles <= (stall && stall_cycles != '1) ? stall_cycles + 32'd1 : stall_cycles;
      fwd_events   <= w_fe[32] ? '1 : w_fe[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// tb_mips_hazard_scoreboard: randomized and directed check of two scoreboard configurations against a queue model.
module tb_mips_hazard_scoreboard;
  localparam int D  = 3;
  localparam int RW = 5;
  localparam int SW = 2;
  logic clk = 0, rst_n = 0;
  logic id_valid = 0, id_src1_used = 0, id_src2_used = 0, id_writes = 0, id_is_load = 0, flush = 0;
  logic [RW-1:0] id_src1 = 0, id_src2 = 0, id_dest = 0;
  logic stall_a, stall_b;
  logic [SW-1:0] s1a, s2a, s1b, s2b;
  logic [D-1:0] inf_a, inf_b;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc_a, fe_a, sc_b, fe_b;
`endif
  int n_err = 0, n_chk = 0;
  int sca = 0, fea = 0, scb = 0, feb = 0;
  typedef struct {bit v; bit w; bit l; int d;} ent_t;
  ent_t qa[$], qb[$];
  always #5 clk = ~clk;
  mips_hazard_scoreboard #(.NUM_REGS(32), .DEPTH(D), .FORWARD(1), .R0_ZERO(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dest(id_dest), .id_writes(id_writes),
    .id_is_load(id_is_load), .flush(flush), .stall(stall_a), .fwd_sel1(s1a), .fwd_sel2(s2a), .inflight(inf_a)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc_a), .fwd_events(fe_a)
`endif
  );
  mips_hazard_scoreboard #(.NUM_REGS(32), .DEPTH(D), .FORWARD(0), .R0_ZERO(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1), .id_src1_used(id_src1_used),
    .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dest(id_dest), .id_writes(id_writes),
    .id_is_load(id_is_load), .flush(flush), .stall(stall_b), .fwd_sel1(s1b), .fwd_sel2(s2b), .inflight(inf_b)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(sc_b), .fwd_events(fe_b)
`endif
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Config 0: full bypass, R0 ordinary. Config 1: no bypass, R0 never hazards.
  // Queue index k-1 holds the instruction k cycles past decode.
  function automatic ent_t ent(int c, int k);
    return c != 0 ? qb[k-1] : qa[k-1];
  endfunction
  function automatic bit hit(int c, int k, int s, bit u);
    ent_t e = ent(c, k);
    return u && e.v && e.w && e.d == s && !(c == 1 && s == 0);
  endfunction
  function automatic int sel(int c, int s, bit u);
    if (c == 1) return 0;
    for (int k = 1; k <= D; k++) if (hit(c, k, s, u)) return k;
    return 0;
  endfunction
  function automatic bit stl(int c);
    bit any = 0;
    for (int k = 1; k <= D; k++)
      if (hit(c, k, int'(id_src1), id_src1_used) || hit(c, k, int'(id_src2), id_src2_used))
        any |= (c == 0) ? (k == 1 && ent(c, 1).l) : (k < D);
    return id_valid && !flush && any;
  endfunction
  function automatic logic [D-1:0] infl(int c);
    logic [D-1:0] r;
    for (int k = 1; k <= D; k++) r[k-1] = ent(c, k).v && ent(c, k).w;
    return r;
  endfunction
  task automatic reset_model();
    ent_t b = '{0, 0, 0, 0};
    qa.delete();
    qb.delete();
    repeat (D) begin qa.push_back(b); qb.push_back(b); end
    sca = 0; fea = 0; scb = 0; feb = 0;
  endtask
  task automatic step();
    bit sa, sb;
    int e1, e2;
    ent_t na, nb;
    #1;
    sa = stl(0);
    sb = stl(1);
    e1 = sel(0, int'(id_src1), id_src1_used);
    e2 = sel(0, int'(id_src2), id_src2_used);
    chk("stall_a", stall_a, sa);
    chk("sel1_a", s1a, e1);
    chk("sel2_a", s2a, e2);
    chk("infl_a", inf_a, infl(0));
    chk("stall_b", stall_b, sb);
    chk("sel1_b", s1b, sel(1, int'(id_src1), id_src1_used));
    chk("sel2_b", s2b, sel(1, int'(id_src2), id_src2_used));
    chk("infl_b", inf_b, infl(1));
`ifdef HAZARD_STATS_EN
    chk("stallcnt_a", sc_a, sca);
    chk("fwdcnt_a", fe_a, fea);
    chk("stallcnt_b", sc_b, scb);
    chk("fwdcnt_b", fe_b, feb);
`endif
    sca += int'(sa);
    scb += int'(sb);
    if (!sa && id_valid) fea += int'(e1 != 0) + int'(e2 != 0);
    na.v = id_valid && !flush && !sa; na.w = na.v && id_writes; na.l = na.v && id_is_load; na.d = int'(id_dest);
    nb.v = id_valid && !flush && !sb; nb.w = nb.v && id_writes; nb.l = nb.v && id_is_load; nb.d = int'(id_dest);
    qa.push_front(na); void'(qa.pop_back());
    qb.push_front(nb); void'(qb.pop_back());
  endtask
  task automatic drv(bit v, int s1, bit u1, int s2, bit u2, int d, bit w, bit ld, bit fl);
    @(negedge clk);
    id_valid = v; id_src1 = RW'(s1); id_src1_used = u1; id_src2 = RW'(s2); id_src2_used = u2;
    id_dest = RW'(d); id_writes = w; id_is_load = ld; flush = fl;
    step();
  endtask
  task automatic drain();
    repeat (D) drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic mid_reset();
    #2 rst_n = 0;
    id_valid = 0;
    flush = 0;
    #1;
    reset_model();
    chk("rst_infl_a", inf_a, 0);
    chk("rst_infl_b", inf_b, 0);
    chk("rst_stall_a", stall_a, 0);
    chk("rst_sel1_a", s1a, 0);
`ifdef HAZARD_STATS_EN
    chk("rst_stallcnt_a", sc_a, 0);
    chk("rst_fwdcnt_a", fe_a, 0);
`endif
    @(negedge clk) rst_n = 1;
  endtask
  initial begin
    reset_model();
    #2;
    chk("init_infl_a", inf_a, 0);
    chk("init_stall_a", stall_a, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    drain();
    // ADD R3, then two readers of R3
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    drv(1, 3, 1, 0, 0, 8, 1, 0, 0);
    chk("t1_sel1", s1a, 1);
    chk("t1_stall", stall_a, 0);
    drv(1, 3, 1, 0, 0, 9, 1, 0, 0);
    chk("t1_sel1_k2", s1a, 2);
    drain();
    // LDW R5, dependent on rt
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0);
    drv(1, 0, 0, 5, 1, 9, 1, 0, 0);
    chk("t2_stall", stall_a, 1);
    drv(1, 0, 0, 5, 1, 9, 1, 0, 0);
    chk("t2_stall_rel", stall_a, 0);
    chk("t2_sel2", s2a, 2);
    drain();
    // No-bypass: writer R7, dependent held two cycles
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0);
    drv(1, 7, 1, 0, 0, 1, 1, 0, 0);
    chk("t3_stall0", stall_b, 1);
    drv(1, 7, 1, 0, 0, 1, 1, 0, 0);
    chk("t3_stall1", stall_b, 1);
    drv(1, 7, 1, 0, 0, 1, 1, 0, 0);
    chk("t3_stall2", stall_b, 0);
    chk("t3_sel1", s1b, 0);
    drain();
    // Two writers of R4, reader on both operands
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 4, 1, 0, 0);
    drv(1, 4, 1, 4, 1, 2, 1, 0, 0);
    chk("t4_sel1", s1a, 1);
    chk("t4_sel2", s2a, 1);
    drain();
    // R0 writer and reader; then flush over a pending load-use hazard
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0);
    drv(1, 0, 1, 0, 0, 2, 1, 0, 0);
    chk("t5_r0_stall", stall_b, 0);
    chk("t5_r0_sel", s1b, 0);
    drain();
    drv(1, 0, 0, 0, 0, 6, 1, 1, 0);
    drv(1, 6, 1, 0, 0, 2, 1, 0, 1);
    chk("t5_flush_stall", stall_a, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_flush_bubble", inf_a[0], 0);
    // Three writers in flight, then reset mid-cycle
    drv(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 2, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    mid_reset();
    drv(1, 3, 1, 2, 1, 4, 1, 0, 0);
    chk("t6_after_rst", stall_b, 0);
    for (int i = 0; i < 3000; i++) begin
      drv($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) mid_reset();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
